// File: rtl/pcie_tlp_requester_if.sv
// Host/endpoint signal bundle for pcie_tlp_requester.
// master = environment (host + endpoint), slave = the requester itself.
interface pcie_tlp_requester_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_config;
    logic        req_is_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [31:0] tlp_data;
    logic        tlp_valid;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        cpl_valid;
    logic [31:0] cpl_data;
    logic        cpl_err;
    logic        busy;

    modport master (
        output req_valid, req_is_config, req_is_write, req_addr, req_wdata,
        output rsp_data, rsp_valid,
        input  req_ready, tlp_data, tlp_valid, cpl_valid, cpl_data, cpl_err, busy
    );

    modport slave (
        input  req_valid, req_is_config, req_is_write, req_addr, req_wdata,
        input  rsp_data, rsp_valid,
        output req_ready, tlp_data, tlp_valid, cpl_valid, cpl_data, cpl_err, busy
    );
endinterface

// File: rtl/pcie_tlp_requester.sv
// Queues host requests, issues one TLP at a time to the endpoint and returns completions.
// Optional response timeout enabled by defining PCIE_TLP_REQ_TIMEOUT_EN.
module pcie_tlp_requester #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    pcie_tlp_requester_if.slave        bus,
    output logic [1:0]                 dbg_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Request handshake: a request transfers on any rising edge where
    // req_valid && req_ready; req_ready is simply "FIFO not full".
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [31:0]      packed_word;

    state_t           state_q;
    logic [31:0]      tlp_data_q;
    logic             tlp_valid_q;
    logic [31:0]      cpl_data_q;
    logic             cpl_valid_q;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.req_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    // Reads carry no payload, so the data field is zeroed at enqueue time.
    assign packed_word = {bus.req_is_config, bus.req_is_write, 6'h00, bus.req_addr,
                          bus.req_is_write ? bus.req_wdata : 16'h0000};

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= packed_word;
    end

`ifdef PCIE_TLP_REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] wait_cnt_q;
    logic            cpl_err_q;
`else
    logic            unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tlp_data_q  <= '0;
            tlp_valid_q <= 1'b0;
            cpl_data_q  <= '0;
            cpl_valid_q <= 1'b0;
`ifdef PCIE_TLP_REQ_TIMEOUT_EN
            wait_cnt_q  <= '0;
            cpl_err_q   <= 1'b0;
`endif
        end else begin
            tlp_valid_q <= 1'b0;
            cpl_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tlp_data_q  <= fifo_mem[rd_ptr_q];
                        tlp_valid_q <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A very fast endpoint may answer while the strobe is still up.
                    if (bus.rsp_valid) begin
                        cpl_valid_q <= 1'b1;
                        cpl_data_q  <= bus.rsp_data;
`ifdef PCIE_TLP_REQ_TIMEOUT_EN
                        cpl_err_q   <= 1'b0;
`endif
                        state_q     <= S_IDLE;
                    end else begin
`ifdef PCIE_TLP_REQ_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        cpl_valid_q <= 1'b1;
                        cpl_data_q  <= bus.rsp_data;
`ifdef PCIE_TLP_REQ_TIMEOUT_EN
                        cpl_err_q   <= 1'b0;
`endif
                        state_q     <= S_IDLE;
                    end
`ifdef PCIE_TLP_REQ_TIMEOUT_EN
                    // Counter holds edges-in-WAIT minus one, so this is the last allowed edge.
                    else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        cpl_valid_q <= 1'b1;
                        cpl_data_q  <= 32'hFFFF_FFFF;
                        cpl_err_q   <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + TO_W'(1);
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.tlp_data  = tlp_data_q;
    assign bus.tlp_valid = tlp_valid_q;
    assign bus.cpl_valid = cpl_valid_q;
    assign bus.cpl_data  = cpl_data_q;
`ifdef PCIE_TLP_REQ_TIMEOUT_EN
    assign bus.cpl_err   = cpl_err_q;
`else
    assign bus.cpl_err   = 1'b0;
`endif
    assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;
    assign dbg_state_o   = state_q;

endmodule
